alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 40 ++++
 rtl/alu_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and iteration count shared by the ALU sequencer
package alu_pkg;

  localparam int ITER_COUNT = 32;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SHR = 4'h2;
  localparam logic [3:0] OP_SHL = 4'h3;
  localparam logic [3:0] OP_ROR = 4'h4;
  localparam logic [3:0] OP_ROL = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_DIV = 4'h9;
  localparam logic [3:0] OP_NEG = 4'hA;
  localparam logic [3:0] OP_NOT = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MUL  = 3'd2,
    ST_DIV  = 3'd3,
    ST_FIX  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational single-cycle ALU; codes without a single-cycle meaning yield 0
module alu
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_sel,
  output logic [31:0] o_z
);

  logic [4:0]  w_sh;
  logic [63:0] w_rot;

  always_comb begin
    w_sh  = i_b[4:0];
    w_rot = {i_a, i_a};
    o_z   = '0;
    case (i_sel)
      OP_ADD: o_z = i_a + i_b;
      OP_SUB: o_z = i_a - i_b;
      OP_SHR: o_z = i_a >> w_sh;
      OP_SHL: o_z = i_a << w_sh;
      // rotates use a doubled word so a zero amount needs no special case
      OP_ROR: begin
        w_rot = {i_a, i_a} >> w_sh;
        o_z   = w_rot[31:0];
      end
      OP_ROL: begin
        w_rot = {i_a, i_a} << w_sh;
        o_z   = w_rot[63:32];
      end
      OP_AND: o_z = i_a & i_b;
      OP_OR:  o_z = i_a | i_b;
      OP_NEG: o_z = -i_a;
      OP_NOT: o_z = ~i_a;
      default: o_z = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - sequences single-cycle ALU ops and iterative signed mul/div
module alu_sequencer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [3:0]  select,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] z,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  state_t      r_state, w_next;
  logic [31:0] r_a, r_b, r_d;
  logic [3:0]  r_sel;
  logic [5:0]  r_cnt;
  logic [63:0] r_p;

  logic [31:0] w_alu_z, w_abs_a, w_abs_b, w_quo, w_rmd;
  logic [32:0] w_sum, w_rem, w_diff;
  logic [63:0] w_prod;
  logic        w_dbz, w_last, w_neg;

  alu u_alu (.i_a(r_a), .i_b(r_b), .i_sel(r_sel), .o_z(w_alu_z));

  assign w_abs_a = a[31] ? -a : a;
  assign w_abs_b = b[31] ? -b : b;
  assign w_dbz   = (r_sel == OP_DIV) && (r_b == '0);
  assign w_last  = (r_cnt == 6'(ITER_COUNT - 1));
  assign w_neg   = r_a[31] ^ r_b[31];

  // r_p is {hi, lo} for mul (multiplier drains from the low end) and {rem, quo} for div
  assign w_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_d} : 33'd0);
  assign w_rem  = r_p[63:31];
  assign w_diff = w_rem - {1'b0, r_d};
  assign w_prod = w_neg ? -r_p : r_p;
  assign w_quo  = w_neg ? -r_p[31:0] : r_p[31:0];
  assign w_rmd  = r_a[31] ? -r_p[63:32] : r_p[63:32];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        if (select == OP_MUL)      w_next = ST_MUL;
        else if (select == OP_DIV) w_next = (b == '0) ? ST_FIX : ST_DIV;
        else                       w_next = ST_EXEC;
      end
      ST_EXEC: begin
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_MUL, ST_DIV: begin
        busy = 1'b1;
        if (w_last) w_next = ST_FIX;
      end
      // divide-by-zero holds FIX for a second cycle so done lands at N+3
      ST_FIX: begin
        busy = 1'b1;
        if (!(w_dbz && r_cnt == '0)) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_a <= '0; r_b <= '0; r_d <= '0; r_sel <= '0; r_cnt <= '0; r_p <= '0;
      z <= '0; hi <= '0; lo <= '0; div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_a   <= a;
          r_b   <= b;
          r_sel <= select;
          r_cnt <= '0;
          r_p   <= {32'd0, w_abs_a};
          r_d   <= w_abs_b;
        end
        ST_EXEC: z <= w_alu_z;
        ST_MUL: begin
          r_p   <= {w_sum, r_p[31:1]};
          r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
        end
        ST_DIV: begin
          r_p   <= w_diff[32] ? {w_rem[31:0], r_p[30:0], 1'b0}
                              : {w_diff[31:0], r_p[30:0], 1'b1};
          r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
        end
        ST_FIX: begin
          if (w_dbz) begin
            hi          <= r_a;
            lo          <= '1;
            div_by_zero <= 1'b1;
            r_cnt       <= (r_cnt == '0) ? 6'd1 : 6'd0;
          end else if (r_sel == OP_MUL) begin
            {hi, lo} <= w_prod;
          end else begin
            hi          <= w_rmd;
            lo          <= w_quo;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed vector table plus hand sequences for alu_sequencer
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        clr, start, busy, done, div_by_zero;
  logic [3:0]  select;
  logic [31:0] a, b, z, hi, lo;

  alu_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .select(select), .a(a), .b(b),
    .busy(busy), .done(done), .z(z), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] z, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add_vec(input logic [3:0] sel, input logic [31:0] va, input logic [31:0] vb,
                         input int lat, input logic [31:0] ez, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edbz);
    vec_t v;
    v.sel = sel; v.a = va; v.b = vb; v.lat = lat;
    v.z = ez; v.hi = ehi; v.lo = elo; v.dbz = edbz;
    vecs.push_back(v);
  endtask

  // returns the cycle offset from the start cycle at which done is seen (-1 on timeout)
  task automatic run_op(input logic [3:0] sel, input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; select = sel; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; select = 4'($urandom_range(0, 15));
    lat = -1; nbusy = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, nbusy, ndone, done_at;
    clr = 1'b1; start = 1'b0; select = '0; a = '0; b = '0;

    add_vec(OP_ADD, 32'd124, 32'd7, 2, 32'h00000083, 32'h0, 32'h0, 1'b0);
    add_vec(OP_SUB, 32'd5, 32'd7, 2, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b0);
    add_vec(OP_SHR, 32'h80000000, 32'd4, 2, 32'h08000000, 32'h0, 32'h0, 1'b0);
    add_vec(OP_SHL, 32'h1, 32'd31, 2, 32'h80000000, 32'h0, 32'h0, 1'b0);
    add_vec(OP_ROR, 32'h12345678, 32'd8, 2, 32'h78123456, 32'h0, 32'h0, 1'b0);
    add_vec(OP_ROL, 32'h12345678, 32'd4, 2, 32'h23456781, 32'h0, 32'h0, 1'b0);
    add_vec(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 2, 32'h00F000F0, 32'h0, 32'h0, 1'b0);
    add_vec(OP_OR,  32'hF0000000, 32'h0000000F, 2, 32'hF000000F, 32'h0, 32'h0, 1'b0);
    add_vec(OP_NEG, 32'd5, 32'd9, 2, 32'hFFFFFFFB, 32'h0, 32'h0, 1'b0);
    add_vec(OP_NOT, 32'h0F0F0F0F, 32'd1, 2, 32'hF0F0F0F0, 32'h0, 32'h0, 1'b0);
    add_vec(4'hC, 32'd1, 32'd2, 2, 32'h0, 32'h0, 32'h0, 1'b0);
    add_vec(OP_MUL, 32'hFFFFFFFA, 32'd7, 34, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    add_vec(OP_ADD, 32'd1, 32'd1, 2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    add_vec(OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    add_vec(OP_DIV, 32'd5, 32'd0, 3, 32'h2, 32'h5, 32'hFFFFFFFF, 1'b1);
    add_vec(OP_MUL, 32'h80000000, 32'h80000000, 34, 32'h2, 32'h40000000, 32'h0, 1'b1);
    add_vec(OP_ROR, 32'hDEADBEEF, 32'd0, 2, 32'hDEADBEEF, 32'h40000000, 32'h0, 1'b1);
    add_vec(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 32'hDEADBEEF, 32'h0, 32'h80000000, 1'b0);
    add_vec(OP_DIV, 32'd100, 32'd7, 34, 32'hDEADBEEF, 32'h2, 32'hE, 1'b0);
    add_vec(OP_DIV, 32'd7, 32'hFFFFFFFE, 34, 32'hDEADBEEF, 32'h1, 32'hFFFFFFFD, 1'b0);
    add_vec(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hDEADBEEF, 32'h0, 32'h1, 1'b0);

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z", z, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, lat, nbusy);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), nbusy, vecs[i].lat - 1);
      check($sformatf("v%0d_z", i), z, vecs[i].z);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
    end

    // start pulses during a mul and in its DONE cycle must be ignored
    @(negedge clk);
    start = 1'b1; select = OP_MUL; a = 32'd3; b = 32'd5;
    ndone = 0; done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == 36) check("ign_busy_idle", busy, 0);
      start = (c == 5 || c == 34);
      select = OP_ADD; a = 32'd100; b = 32'd100;
    end
    start = 1'b0;
    check("ign_ndone", ndone, 1);
    check("ign_done_at", done_at, 34);
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'hF);
    check("ign_z", z, 32'hDEADBEEF);

    // clr mid-division abandons it immediately with no done pulse
    @(negedge clk);
    start = 1'b1; select = OP_DIV; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    clr = 1'b1;
    #1;
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_z", z, 0);
    check("clr_hi", hi, 0);
    check("clr_lo", lo, 0);
    check("clr_dbz", div_by_zero, 0);
    @(negedge clk);
    clr = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("clr_no_done", ndone, 0);
    run_op(OP_ADD, 32'd2, 32'd3, lat, nbusy);
    check("post_clr_lat", lat, 2);
    check("post_clr_z", z, 32'd5);
    check("post_clr_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
